iob_sram_port_arb: RTL and testbench



---
 rtl/iob_sram_port_arb_pkg.sv | 47 ++++
 rtl/iob_rr_pick.sv | 34 +++
 rtl/iob_sram_port_arb.sv | 191 +++++++++++++++++++
 tb/tb_iob_sram_port_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_sram_port_arb_pkg.sv
// Shared definitions for the IOb SRAM port arbiter and the other IOb bus merges.
package iob_sram_port_arb_pkg;

  // Default IOb native-bus field widths
  localparam int IOB_ADDR_W = 32;
  localparam int IOB_DATA_W = 32;
  localparam int IOB_STRB_W = IOB_DATA_W / 8;

  // Request bundle layout, LSB first: wstrb | wdata | addr | avalid
  localparam int REQ_WSTRB_OFF  = 0;
  localparam int REQ_WDATA_OFF  = REQ_WSTRB_OFF + IOB_STRB_W;
  localparam int REQ_ADDR_OFF   = REQ_WDATA_OFF + IOB_DATA_W;
  localparam int REQ_AVALID_OFF = REQ_ADDR_OFF + IOB_ADDR_W;
  localparam int REQ_W          = REQ_AVALID_OFF + 1;

  // Response bundle layout, LSB first: rdata | rvalid | ready
  localparam int RESP_RDATA_OFF  = 0;
  localparam int RESP_RVALID_OFF = RESP_RDATA_OFF + IOB_DATA_W;
  localparam int RESP_READY_OFF  = RESP_RVALID_OFF + 1;
  localparam int RESP_W          = RESP_READY_OFF + 1;

  // The slave answers every read one cycle later, so two outstanding reads is the ceiling
  localparam int PEND_W   = 2;
  localparam int PEND_MAX = 2;

  // Burst counter covers limits up to 15
  localparam int CNT_W = 4;

  typedef logic [PEND_W-1:0] pend_t;

  // Effect of one cycle on the outstanding-read count
  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC,
    PEND_OVF
  } pend_op_e;

  // Index width for n requesters, never below one bit
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or above
// start_ptr, wrapping modulo N. Masters set in excl are skipped.
module iob_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start_ptr,
  input  logic [N-1:0]     excl,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] elig;

  assign elig = req & ~excl;

  // Walk the requesters in rotated order and keep the first eligible one
  always_comb begin
    int cand;
    cand  = 0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = int'(start_ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/iob_sram_port_arb.sv
// Arbitrates N IOb masters onto one SRAM port. Round-robin grant with a
// per-owner burst limit; a pending-read counter pins ownership while reads
// are in flight so that every response is routed to the master that issued it.
module iob_sram_port_arb
  import iob_sram_port_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = IOB_ADDR_W,
  parameter int DATA_W    = IOB_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_i,
  input  logic [N_MASTERS-1:0]          m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic [DATA_W-1:0]             s_rdata_i,
  input  logic                          s_rvalid_i,
  input  logic                          s_ready_i,
  output logic                          err_o
);

  localparam int IDX_W  = idx_w(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] own_q, own_d;
  pend_t            pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N_MASTERS-1:0] own_mask;
  logic [N_MASTERS-1:0] excl;
  logic                 other_req;
  logic                 burst_hit;
  logic                 blocked;
  logic                 pend_nz;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] win_idx;
  logic             win_req;
  logic             win_valid;

  logic     accept;
  logic     rd_acc;
  logic     rv_ok;
  logic     rv_stray;
  pend_op_e pend_op;

  // One-hot view of the current owner
  always_comb begin
    own_mask         = '0;
    own_mask[own_q]  = 1'b1;
  end

  assign pend_nz   = (pend_q != '0);
  assign other_req = |(m_avalid_i & ~own_mask);
  assign burst_hit = (cnt_q >= CNT_W'(BURST_MAX));
  assign blocked   = burst_hit & other_req;
  assign excl      = blocked ? own_mask : '0;

  iob_rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (m_avalid_i),
    .start_ptr (ptr_q),
    .excl      (excl),
    .idx       (pick_idx),
    .found     (pick_found)
  );

  // While reads are in flight only the owner may continue, and only inside its burst budget
  always_comb begin
    if (pend_nz) begin
      win_idx = own_q;
      win_req = m_avalid_i[own_q] & ~blocked;
    end else begin
      win_idx = pick_idx;
      win_req = pick_found;
    end
  end

  // Nothing is presented to the slave while reset is held
  assign win_valid  = win_req & ~arst_i;
  assign s_avalid_o = win_valid;
  assign accept     = win_valid & s_ready_i;
  assign rd_acc     = accept & ~(|s_wstrb_o);

  // Forward the winner's request with no added latency and steer the slave's accept back to it
  always_comb begin
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    m_ready_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (win_valid && (win_idx == IDX_W'(k))) begin
        s_addr_o     = m_addr_i[k*ADDR_W +: ADDR_W];
        s_wdata_o    = m_wdata_i[k*DATA_W +: DATA_W];
        s_wstrb_o    = m_wstrb_i[k*STRB_W +: STRB_W];
        m_ready_o[k] = s_ready_i;
      end
    end
  end

  // A response with nothing outstanding is stray and never reaches a master
  assign rv_ok    = s_rvalid_i & pend_nz;
  assign rv_stray = s_rvalid_i & ~pend_nz;

  // Route responses to the owner; ownership is frozen while reads are pending
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!arst_i && (own_q == IDX_W'(k))) begin
        m_rvalid_o[k]                  = rv_ok;
        m_rdata_o[k*DATA_W +: DATA_W]  = s_rdata_i;
      end
    end
  end

  // Classify this cycle's effect on the outstanding-read count
  always_comb begin
    pend_op = PEND_HOLD;
    if (rd_acc && !rv_ok) begin
      pend_op = (pend_q == pend_t'(PEND_MAX)) ? PEND_OVF : PEND_INC;
    end else if (!rd_acc && rv_ok) begin
      pend_op = PEND_DEC;
    end
  end

  // Outstanding-read count and sticky error; overflow saturates instead of wrapping
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q | rv_stray;
    case (pend_op)
      PEND_INC: pend_d = pend_q + 1'b1;
      PEND_DEC: pend_d = pend_q - 1'b1;
      PEND_OVF: err_d  = 1'b1;
      default:  pend_d = pend_q;
    endcase
  end

  // Ownership, rotation pointer and burst count advance on each accepted transaction
  always_comb begin
    own_d = own_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (accept) begin
      own_d = win_idx;
      ptr_d = (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;
      if (win_idx != own_q) begin
        cnt_d = CNT_W'(1);
      end else if (!burst_hit) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!(|m_avalid_i)) begin
      cnt_d = '0;
    end
  end

  assign err_o = err_q & ~arst_i;

  // State register: reset wins over the clock enable
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      ptr_q  <= '0;
      own_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (cke_i) begin
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_iob_sram_port_arb.sv
// Bench for iob_sram_port_arb: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_iob_sram_port_arb;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int BM = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            cke_i;
  logic            arst_i;
  logic [N-1:0]    m_avalid_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N*SW-1:0] m_wstrb_i;
  logic [N-1:0]    m_ready_o;
  logic [N*DW-1:0] m_rdata_o;
  logic [N-1:0]    m_rvalid_o;
  logic            s_avalid_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic [SW-1:0]   s_wstrb_o;
  logic [DW-1:0]   s_rdata_i;
  logic            s_rvalid_i;
  logic            s_ready_i;
  logic            err_o;

  iob_sram_port_arb #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk_i      (clk_i),
    .cke_i      (cke_i),
    .arst_i     (arst_i),
    .m_avalid_i (m_avalid_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_wstrb_i  (m_wstrb_i),
    .m_ready_o  (m_ready_o),
    .m_rdata_o  (m_rdata_o),
    .m_rvalid_o (m_rvalid_o),
    .s_avalid_o (s_avalid_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wstrb_o  (s_wstrb_o),
    .s_rdata_i  (s_rdata_i),
    .s_rvalid_i (s_rvalid_i),
    .s_ready_i  (s_ready_i),
    .err_o      (err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: last accepted master, rotation start, run length, and
  // a queue holding the issuing master of every read still awaiting data.
  int md_own;
  int md_ptr;
  int md_cnt;
  bit md_err;
  int md_pend[$];

  bit slv_ret;
  bit stray;
  bit acc_v;
  int acc_w;

  logic          obs_avalid;
  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_rvalid;
  logic          obs_err;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Which master should be granted, judged from the arbitration rules
  function automatic void model_pick(output bit v, output int w);
    bit others;
    bit capped;
    int c;
    others = 1'b0;
    for (int k = 0; k < N; k++) if (k != md_own && m_avalid_i[k]) others = 1'b1;
    capped = (md_cnt == BM) && others;
    v = 1'b0;
    w = 0;
    c = 0;
    if (md_pend.size() > 0) begin
      w = md_own;
      v = m_avalid_i[md_own] && !capped;
    end else begin
      for (int o = 0; o < N; o++) begin
        c = (md_ptr + o) % N;
        if (!v && m_avalid_i[c] && !(capped && c == md_own)) begin
          v = 1'b1;
          w = c;
        end
      end
    end
  endfunction

  task automatic drive_slave();
    s_rvalid_i = slv_ret || stray;
    s_rdata_i  = (slv_ret || stray) ? DW'($urandom()) : '0;
    stray      = 1'b0;
  endtask

  task automatic set_m(input int k, input bit av, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_avalid_i[k]        = av;
    m_addr_i[k*AW +: AW] = a;
    m_wdata_i[k*DW +: DW] = d;
    m_wstrb_i[k*SW +: SW] = s;
  endtask

  task automatic rand_master(input int k);
    logic [SW-1:0] s;
    s = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom_range(1, 15));
    set_m(k, ($urandom_range(0, 99) < 60), AW'($urandom()) & 32'hFFFF_FFFC, DW'($urandom()), s);
  endtask

  // One clock: compare all outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    bit v;
    int w;
    bit ok;
    bit rd;
    int sz;
    logic [N-1:0]    e_ready;
    logic [N-1:0]    e_rvalid;
    logic [N*DW-1:0] e_rdata;
    @(negedge clk_i);
    model_pick(v, w);
    if (arst_i) v = 1'b0;
    sz = md_pend.size();
    ok = s_rvalid_i && (sz > 0) && !arst_i;
    e_ready = '0;
    if (v && s_ready_i) e_ready[w] = 1'b1;
    e_rvalid = '0;
    if (ok) e_rvalid[md_pend[0]] = 1'b1;
    e_rdata = '0;
    if (!arst_i) e_rdata[md_own*DW +: DW] = s_rdata_i;
    obs_avalid = s_avalid_o;
    obs_ready  = m_ready_o;
    obs_rvalid = m_rvalid_o;
    obs_err    = err_o;
    obs_addr   = s_addr_o;
    chk("s_avalid", s_avalid_o, v);
    if (v) begin
      chk("s_addr", s_addr_o, m_addr_i[w*AW +: AW]);
      chk("s_wdata", s_wdata_o, m_wdata_i[w*DW +: DW]);
      chk("s_wstrb", s_wstrb_o, m_wstrb_i[w*SW +: SW]);
    end
    chk("m_ready", m_ready_o, e_ready);
    chk("m_rvalid", m_rvalid_o, e_rvalid);
    chk("m_rdata", m_rdata_o, e_rdata);
    chk("err", err_o, md_err && !arst_i);
    @(posedge clk_i);
    rd    = v && s_ready_i && (m_wstrb_i[w*SW +: SW] == '0);
    acc_v = v && s_ready_i;
    acc_w = w;
    if (arst_i) begin
      md_own = 0;
      md_ptr = 0;
      md_cnt = 0;
      md_err = 1'b0;
      md_pend.delete();
      slv_ret = 1'b0;
    end else begin
      if (cke_i) begin
        ok = s_rvalid_i && (sz > 0);
        if (s_rvalid_i && sz == 0) md_err = 1'b1;
        if (ok) void'(md_pend.pop_front());
        if (rd) begin
          if (sz == 2 && !ok) md_err = 1'b1;
          else md_pend.push_back(w);
        end
        if (v && s_ready_i) begin
          if (w == md_own) md_cnt = (md_cnt + 1 > BM) ? BM : md_cnt + 1;
          else md_cnt = 1;
          md_own = w;
          md_ptr = (w + 1) % N;
        end else if (m_avalid_i == '0) begin
          md_cnt = 0;
        end
      end
      slv_ret = rd;
    end
    #1;
    drive_slave();
  endtask

  task automatic do_reset();
    m_avalid_i = '0;
    arst_i     = 1'b1;
    cycle();
    arst_i     = 1'b0;
  endtask

  logic [N-1:0] t2_exp [4];
  int  run;
  bit  got0;

  initial begin
    cke_i      = 1'b1;
    arst_i     = 1'b1;
    m_avalid_i = '0;
    m_addr_i   = '0;
    m_wdata_i  = '0;
    m_wstrb_i  = '0;
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    stray      = 1'b0;
    slv_ret    = 1'b0;
    md_own = 0; md_ptr = 0; md_cnt = 0; md_err = 1'b0;
    acc_v = 1'b0; acc_w = 0;

    // Reset values, during and just after reset
    cycle();
    cycle();
    chk("rst_avalid", obs_avalid, 1'b0);
    chk("rst_ready", obs_ready, '0);
    chk("rst_err", obs_err, 1'b0);
    arst_i    = 1'b0;
    s_ready_i = 1'b1;
    cycle();
    chk("post_rst_avalid", obs_avalid, 1'b0);
    chk("post_rst_rvalid", obs_rvalid, '0);

    // Back-to-back reads from master 0
    set_m(0, 1'b1, 32'h10, 32'h0, '0);
    cycle();
    chk("t1_avalid_c1", obs_avalid, 1'b1);
    chk("t1_addr_c1", obs_addr, 32'h10);
    set_m(0, 1'b1, 32'h14, 32'h0, '0);
    cycle();
    chk("t1_addr_c2", obs_addr, 32'h14);
    chk("t1_rvalid_c2", obs_rvalid, 2'b01);
    m_avalid_i[0] = 1'b0;
    cycle();
    chk("t1_rvalid_c3", obs_rvalid, 2'b01);
    cycle();
    chk("t1_rvalid_c4", obs_rvalid, 2'b00);

    // Both masters writing continuously from reset alternate
    do_reset();
    set_m(0, 1'b1, 32'h100, 32'h1111, 4'hF);
    set_m(1, 1'b1, 32'h200, 32'h2222, 4'hF);
    t2_exp[0] = 2'b01; t2_exp[1] = 2'b10; t2_exp[2] = 2'b01; t2_exp[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_order", obs_ready, t2_exp[i]);
    end

    // Master 1 waits until master 0's pipelined reads drain
    do_reset();
    set_m(0, 1'b1, 32'h20, 32'h0, '0);
    cycle();
    set_m(0, 1'b1, 32'h24, 32'h0, '0);
    set_m(1, 1'b1, 32'h300, 32'h3333, 4'h3);
    cycle();
    chk("t3_m1_held_c2", obs_ready, 2'b01);
    set_m(0, 1'b1, 32'h28, 32'h0, '0);
    cycle();
    chk("t3_m1_held_c3", obs_ready, 2'b01);
    m_avalid_i[0] = 1'b0;
    cycle();
    chk("t3_last_rvalid", obs_rvalid, 2'b01);
    chk("t3_no_grant", obs_ready, 2'b00);
    cycle();
    chk("t3_m1_grant", obs_ready, 2'b10);
    chk("t3_no_stray_rvalid", obs_rvalid, 2'b00);
    m_avalid_i = '0;
    cycle();

    // Burst limit when master 0 joins a long master-1 read stream
    do_reset();
    set_m(1, 1'b1, 32'h400, 32'h0, '0);
    for (int i = 0; i < 10; i++) cycle();
    set_m(0, 1'b1, 32'h500, 32'h5555, 4'hF);
    run  = 0;
    got0 = 1'b0;
    for (int i = 0; i < 12 && !got0; i++) begin
      cycle();
      if (obs_ready[0]) got0 = 1'b1;
      else if (obs_ready[1]) run++;
    end
    chk("t4_m0_granted", got0, 1'b1);
    chk("t4_m1_run_le_max", (run <= BM), 1'b1);
    m_avalid_i = '0;
    cycle();
    cycle();

    // Slave stall holds the request stable
    do_reset();
    s_ready_i = 1'b0;
    set_m(1, 1'b1, 32'h40, 32'hA5A5_0001, '0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_avalid", obs_avalid, 1'b1);
      chk("t5_addr", obs_addr, 32'h40);
      chk("t5_ready", obs_ready, 2'b00);
    end
    s_ready_i = 1'b1;
    cycle();
    chk("t5_accept", obs_ready, 2'b10);
    m_avalid_i = '0;
    cycle();
    chk("t5_rvalid", obs_rvalid, 2'b10);
    cycle();
    chk("t5_no_err", obs_err, 1'b0);

    // Stray response, then reset with a read in flight
    do_reset();
    stray = 1'b1;
    cycle();
    cycle();
    chk("t6_stray_dropped", obs_rvalid, 2'b00);
    cycle();
    chk("t6_err_set", obs_err, 1'b1);
    cycle();
    chk("t6_err_sticky", obs_err, 1'b1);
    set_m(1, 1'b1, 32'h80, 32'h0, '0);
    cycle();
    chk("t6_read_accept", obs_ready, 2'b10);
    m_avalid_i = '0;
    arst_i = 1'b1;
    stray  = 1'b1;
    cycle();
    chk("t6_rst_rvalid", obs_rvalid, 2'b00);
    chk("t6_rst_err", obs_err, 1'b0);
    arst_i = 1'b0;
    cycle();
    chk("t6_post_rst_stray", obs_rvalid, 2'b00);
    cycle();
    chk("t6_post_rst_err", obs_err, 1'b1);
    do_reset();
    cycle();
    chk("t6_clear_err", obs_err, 1'b0);
    chk("t6_clear_avalid", obs_avalid, 1'b0);

    // Clock enable low: a stray response leaves state untouched
    cke_i = 1'b0;
    stray = 1'b1;
    cycle();
    cycle();
    chk("cke_rvalid", obs_rvalid, 2'b00);
    cke_i = 1'b1;
    cycle();
    chk("cke_err_held", obs_err, 1'b0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!m_avalid_i[k] || (acc_v && acc_w == k)) rand_master(k);
      end
      s_ready_i = ($urandom_range(0, 99) < 80);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
